// File: rtl/mux_n_1_reg.sv
// Registered N:1 bus multiplexer with a valid/ready channel select, one-cycle
// blanking on every channel change, and an auto-scan mode with fixed dwell.
module mux_n_1_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int DWELL = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N*WIDTH-1:0]       data_in,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [$clog2(N)-1:0]     sel_in,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    output logic                     sel_err,
    output logic [$clog2(N)-1:0]     cur_sel,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid
);

    localparam int SEL_W = $clog2(N);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SEL_W:0]   N_EXT      = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SWITCH
    } state_t;

    state_t            state_q;
    logic [SEL_W-1:0]  cur_sel_q;
    logic [DW_W-1:0]   dwell_q;
    logic [WIDTH-1:0]  out_q;
    logic              out_valid_q;
    logic              sel_err_q;

    logic              sel_accept;
    logic              sel_bad;
    logic              sel_good;
    logic [WIDTH-1:0]  sel_data;
    logic [SEL_W-1:0]  scan_next;

    assign sel_ready  = !mode && (state_q != SWITCH);
    assign sel_accept = sel_valid && sel_ready;
    assign sel_bad    = sel_accept && ({1'b0, sel_in} >= N_EXT);
    assign sel_good   = sel_accept && !sel_bad;
    assign sel_data   = data_in[cur_sel_q*WIDTH +: WIDTH];
    // Explicit wrap keeps cur_sel inside 0..N-1 when N is not a power of two.
    assign scan_next  = (cur_sel_q == SEL_LAST) ? '0 : cur_sel_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_sel_q   <= '0;
            dwell_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every register
            // samples the pre-edge values; later defaults are overridden below.
            sel_err_q <= sel_bad;
            dwell_q   <= '0;
            if (!enable) begin
                state_q     <= IDLE;
                out_q       <= '0;
                out_valid_q <= 1'b0;
                if (sel_good) cur_sel_q <= sel_in;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q     <= ACTIVE;
                        out_q       <= sel_data;
                        out_valid_q <= 1'b1;
                        if (sel_good) cur_sel_q <= sel_in;
                    end
                    ACTIVE: begin
                        if (sel_good && (sel_in != cur_sel_q)) begin
                            cur_sel_q   <= sel_in;
                            state_q     <= SWITCH;
                            out_q       <= '0;
                            out_valid_q <= 1'b0;
                        end else if (mode && (dwell_q == DWELL_LAST)) begin
                            cur_sel_q   <= scan_next;
                            state_q     <= SWITCH;
                            out_q       <= '0;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_q       <= sel_data;
                            out_valid_q <= 1'b1;
                            if (mode) dwell_q <= dwell_q + 1'b1;
                        end
                    end
                    SWITCH: begin
                        state_q     <= ACTIVE;
                        out_q       <= sel_data;
                        out_valid_q <= 1'b1;
                    end
                    default: begin
                        state_q     <= IDLE;
                        out_q       <= '0;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel_err   = sel_err_q;
    assign cur_sel   = cur_sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Directed bench for mux_n_1_reg: N=4 main instance plus an N=3 instance for
// out-of-range select handling. Outputs are sampled 1 ns after the rising edge.
module tb_mux_n_1_reg;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        enable;
    logic        mode;
    logic [1:0]  sel_in;
    logic        sel_valid;
    logic        sel_valid3;

    logic        sel_ready,  sel_err,  out_valid;
    logic [1:0]  cur_sel;
    logic [7:0]  out;
    logic        sel_ready3, sel_err3, out_valid3;
    logic [1:0]  cur_sel3;
    logic [7:0]  out3;

    int n_vec = 0;
    int n_err = 0;

    mux_n_1_reg #(.WIDTH(8), .N(4), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .enable(enable), .mode(mode),
        .sel_in(sel_in), .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_err(sel_err),
        .cur_sel(cur_sel), .out(out), .out_valid(out_valid)
    );

    mux_n_1_reg #(.WIDTH(8), .N(3), .DWELL(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in[23:0]), .enable(enable), .mode(mode),
        .sel_in(sel_in), .sel_valid(sel_valid3), .sel_ready(sel_ready3), .sel_err(sel_err3),
        .cur_sel(cur_sel3), .out(out3), .out_valid(out_valid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_sel;
        logic [7:0] exp_out;

        rst_n      = 1'b0;
        data_in    = 32'h44332211;
        enable     = 1'b0;
        mode       = 1'b0;
        sel_in     = 2'd0;
        sel_valid  = 1'b0;
        sel_valid3 = 1'b0;
        #12;
        check("rst_out",       32'(out),       32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_cur_sel",   32'(cur_sel),   32'h0);
        check("rst_sel_err",   32'(sel_err),   32'h0);
        #10 rst_n = 1'b1;

        tick();
        check("idle_out_valid", 32'(out_valid), 32'h0);
        check("idle_sel_ready", 32'(sel_ready), 32'h1);

        // Enable in manual mode: channel 0 after one edge.
        enable = 1'b1;
        tick();
        check("en_out",       32'(out),       32'h11);
        check("en_out_valid", 32'(out_valid), 32'h1);
        check("en_sel_ready", 32'(sel_ready), 32'h1);

        // Output tracks the input with one register delay.
        data_in[7:0] = 8'h5A;
        tick();
        check("track_out", 32'(out), 32'h5A);
        data_in[7:0] = 8'h11;
        tick();
        check("track_back", 32'(out), 32'h11);

        // Manual change to channel 2: exactly one blank cycle.
        sel_in    = 2'd2;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("sw_cur_sel",   32'(cur_sel),   32'h2);
        check("sw_out_valid", 32'(out_valid), 32'h0);
        check("sw_out",       32'(out),       32'h0);
        check("sw_sel_ready", 32'(sel_ready), 32'h0);
        tick();
        check("sw_new_out",   32'(out),       32'h33);
        check("sw_new_valid", 32'(out_valid), 32'h1);

        // Re-select the current channel: no blanking.
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("resel_out",   32'(out),       32'h33);
        check("resel_valid", 32'(out_valid), 32'h1);
        check("resel_err",   32'(sel_err),   32'h0);

        // Out-of-range select on the N=3 instance.
        check("n3_sel_ready", 32'(sel_ready3), 32'h1);
        sel_in     = 2'd3;
        sel_valid3 = 1'b1;
        tick();
        sel_valid3 = 1'b0;
        check("bad_sel_err",   32'(sel_err3),   32'h1);
        check("bad_cur_sel",   32'(cur_sel3),   32'h0);
        check("bad_out_valid", 32'(out_valid3), 32'h1);
        check("bad_out",       32'(out3),       32'h11);
        tick();
        check("bad_err_pulse", 32'(sel_err3),   32'h0);

        // Handshake while disabled still moves cur_sel.
        enable    = 1'b0;
        sel_in    = 2'd0;
        sel_valid = 1'b1;
        tick();
        check("dis_out_valid", 32'(out_valid), 32'h0);
        check("dis_cur_sel",   32'(cur_sel),   32'h0);

        // Scan mode with a select request held high that must be ignored.
        sel_in = 2'd3;
        mode   = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            exp_sel = 2'(((i + 1) / 5) % 4);
            exp_out = (i % 5 == 4) ? 8'h00 : 8'h11 * (8'(exp_sel) + 8'd1);
            check($sformatf("scan%0d_out", i),   32'(out),       32'(exp_out));
            check($sformatf("scan%0d_valid", i), 32'(out_valid), (i % 5 == 4) ? 32'h0 : 32'h1);
            check($sformatf("scan%0d_sel", i),   32'(cur_sel),   32'(exp_sel));
            check($sformatf("scan%0d_ready", i), 32'(sel_ready), 32'h0);
        end

        // Now in SWITCH toward channel 1: drop enable and mode together.
        enable    = 1'b0;
        mode      = 1'b0;
        sel_valid = 1'b0;
        tick();
        check("drop_out",       32'(out),       32'h0);
        check("drop_out_valid", 32'(out_valid), 32'h0);
        check("drop_cur_sel",   32'(cur_sel),   32'h1);
        enable = 1'b1;
        tick();
        check("reen_out",       32'(out),       32'h22);
        check("reen_out_valid", 32'(out_valid), 32'h1);

        // Scan up to channel 2, then reset asynchronously mid-dwell.
        mode = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_sel", 32'(cur_sel), 32'h2);
        check("pre_rst_out", 32'(out),     32'h33);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out",       32'(out),       32'h0);
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_cur_sel",   32'(cur_sel),   32'h0);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_out",   32'(out),       32'h11);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_dwell%0d", i), 32'(out), 32'h11);
        end
        tick();
        check("post_rst_blank", 32'(out_valid), 32'h0);
        check("post_rst_next",  32'(cur_sel),   32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_n_1_reg.md
# mux_n_1_reg

Parametrised, registered N:1 multiplexer for WIDTH-bit buses. It adds a valid/ready select handshake, a one-cycle blanking interval on every channel change, and an auto-scan mode that steps through all channels with a fixed dwell time. It replaces the single-bit combinational 2:1 mux wherever channel selection comes from control logic or a sequencer, and a registered, glitch-free output is required.

## Interface
Parameters:
- WIDTH, 8, data width per channel (≥1)
- N, 4, number of input channels (≥2); SEL_W = $clog2(N) is derived locally
- DWELL, 16, cycles each channel stays valid in scan mode (≥1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  N*WIDTH  concatenated channels; channel i occupies bits [i*WIDTH +: WIDTH], channel 0 at the LSBs
- enable  in  1  1 = output active, 0 = output forced idle
- mode  in  1  0 = manual select, 1 = auto-scan
- sel_in  in  SEL_W  requested channel
- sel_valid  in  1  sel_in is valid
- sel_ready  out  1  a select can be accepted (combinational)
- sel_err  out  1  one-cycle pulse when an out-of-range select is accepted
- cur_sel  out  SEL_W  currently selected channel
- out  out  WIDTH  registered selected data
- out_valid  out  1  out holds valid channel data

## Operation
- States: IDLE, ACTIVE, SWITCH. Reset values: state = IDLE, out = 0, out_valid = 0, cur_sel = 0, sel_err = 0, dwell counter = 0.
- Priority on each edge: enable = 0 beats everything else. The next state is IDLE with out = 0 and out_valid = 0. cur_sel is retained, and a handshake in the same cycle still updates cur_sel.
- sel_ready = (mode == 0) && (state != SWITCH). No selects are accepted in scan mode.
- Accept condition: sel_valid && sel_ready.
  - sel_in ≥ N: cur_sel is unchanged, sel_err = 1 for one cycle, and the state is unaffected.
  - sel_in == cur_sel: the select is accepted with no blanking; ACTIVE stays ACTIVE.
  - sel_in ≠ cur_sel, in ACTIVE: cur_sel <= sel_in, state <= SWITCH, out <= 0, out_valid <= 0.
  - Any accept in IDLE only updates cur_sel; there is no SWITCH.
- IDLE with enable = 1: state <= ACTIVE, out <= data_in[cur_sel], out_valid <= 1.
- ACTIVE: out <= data_in[cur_sel] every cycle and out_valid <= 1. The output tracks the input with a one-cycle register delay.
- SWITCH: lasts exactly one cycle, then state <= ACTIVE and the output loads from the new cur_sel.
- Scan mode, in ACTIVE:
  - The dwell counter increments every cycle.
  - When dwell == DWELL-1: cur_sel <= (cur_sel == N-1) ? 0 : cur_sel+1, state <= SWITCH, dwell <= 0.
  - Wrap-around is N-1 → 0. This also holds for non-power-of-2 N; cur_sel never exceeds N-1.
- The dwell counter clears to 0 whenever:
  - mode = 0,
  - state ≠ ACTIVE, or
  - mode rises.
- A mode change takes effect on the next edge.
- A scan step in progress (SWITCH) completes normally if mode drops during it.

## Timing
- Data latency: data_in sampled at edge k appears on out after edge k, with out_valid = 1.
- Channel change, manual: handshake at edge k gives cur_sel new after k and out_valid = 0 for cycle k→k+1. New-channel data appears after edge k+1. Blanking is exactly one cycle.
- Scan period per channel: DWELL valid cycles plus 1 blanking cycle. A full rotation takes N*(DWELL+1) cycles.
- enable 1→0 at edge k: out = 0 and out_valid = 0 after k.
- enable 0→1 at edge k: valid data after k. There is no blanking.
- An asynchronous rst_n assertion mid-operation immediately forces all reset values. Operation restarts from IDLE with cur_sel = 0 on the first edge after deassertion.
- sel_err is registered and is never high for more than one cycle per accepted bad select.

## Test plan
Unless stated otherwise, WIDTH=8, N=4, DWELL=4, and data_in channels = {8'h44, 8'h33, 8'h22, 8'h11} (channel 3 → channel 0).
- Reset, then enable=1, mode=0: out=8'h11 with out_valid=1 one cycle after enable. sel_ready=1.
- Select 2 handshake from ACTIVE: cur_sel=2 and out_valid=0 for exactly one cycle, then out=8'h33. Re-select 2: no blanking, out stays 8'h33.
- sel_in=5 with N=5 (or sel_in=3 with N=3): sel_err high for one cycle, cur_sel unchanged, out_valid stays 1.
- mode=1, enable=1: out sequence 11×4, blank, 22×4, blank, 33×4, blank, 44×4, blank, 11 (wrap). sel_ready=0 throughout, and sel_valid is ignored.
- enable dropped during SWITCH: IDLE next cycle, out=0, out_valid=0. Re-enable: out shows the new cur_sel data after one edge.
- rst_n pulsed low mid-scan at cur_sel=2: outputs are 0 immediately. After release with enable=1, out=8'h11 and dwell restarts from 0.
